// File: rtl/cmd_to_sbus_if.sv
// Signal bundle between the host byte streams, the split bus and cmd_to_sbus.
// master = the decoder side, slave = host/bus-slave side.
interface cmd_to_sbus_if #(
    parameter int ABUSWIDTH = 16
);
    logic [7:0]           CMD_DATA;
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [7:0]           RSP_DATA;
    logic                 RSP_VALID;
    logic                 RSP_READY;
    logic [ABUSWIDTH-1:0] BUS_ADD;
    logic [7:0]           BUS_DATA_OUT;
    logic [7:0]           BUS_DATA_IN;
    logic                 BUS_WR;
    logic                 BUS_RD;
    logic                 BUSY;

    modport master (
        input  CMD_DATA, CMD_VALID,
        output CMD_READY,
        output RSP_DATA, RSP_VALID,
        input  RSP_READY,
        output BUS_ADD, BUS_DATA_OUT,
        input  BUS_DATA_IN,
        output BUS_WR, BUS_RD, BUSY
    );

    modport slave (
        output CMD_DATA, CMD_VALID,
        input  CMD_READY,
        input  RSP_DATA, RSP_VALID,
        output RSP_READY,
        input  BUS_ADD, BUS_DATA_OUT,
        output BUS_DATA_IN,
        input  BUS_WR, BUS_RD, BUSY
    );
endinterface

// File: rtl/cmd_to_sbus.sv
// Byte-stream command decoder driving single-cycle BUS_WR/BUS_RD strobes,
// with burst length, address auto-increment and a read-data return stream.
module cmd_to_sbus #(
    parameter int READ_LATENCY = 1,
    parameter int ABUSWIDTH    = 16
) (
    input logic          BUS_CLK,
    input logic          BUS_RST_N,
    cmd_to_sbus_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR_H    = 3'd1;
    localparam logic [2:0] ADDR_L    = 3'd2;
    localparam logic [2:0] WR_DATA   = 3'd3;
    localparam logic [2:0] WR_STROBE = 3'd4;
    localparam logic [2:0] RD_STROBE = 3'd5;
    localparam logic [2:0] RD_WAIT   = 3'd6;
    localparam logic [2:0] RD_OUT    = 3'd7;

    logic [2:0]           state_reg;
    logic                 dir_reg;
    logic [6:0]           remain_reg;   // transactions still to go after the current one
    logic [7:0]           addr_h_reg;
    logic [ABUSWIDTH-1:0] addr_reg;
    logic [1:0]           wait_reg;
    logic [ABUSWIDTH-1:0] bus_add_reg;
    logic [7:0]           data_out_reg;
    logic [7:0]           rsp_data_reg;
    logic                 rsp_valid_reg;
    logic                 wr_reg;
    logic                 rd_reg;

    logic                 cmd_ready;
    logic                 cmd_accept;
    logic                 last_xfer;
    logic [ABUSWIDTH-1:0] addr_next;
    logic [ABUSWIDTH-1:0] addr_frame;

    assign cmd_ready  = BUS_RST_N && (state_reg inside {IDLE, ADDR_H, ADDR_L, WR_DATA});
    assign cmd_accept = cmd_ready && bus.CMD_VALID;
    assign last_xfer  = (remain_reg == 7'd0);
    assign addr_next  = addr_reg + ABUSWIDTH'(1);
    assign addr_frame = ABUSWIDTH'({addr_h_reg, bus.CMD_DATA});

    // BUS_ADD is only reloaded on the edge that opens a strobe cycle, so it
    // keeps its last value while a new frame header is being parsed.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_reg     <= IDLE;
            dir_reg       <= 1'b0;
            remain_reg    <= '0;
            addr_h_reg    <= '0;
            addr_reg      <= '0;
            wait_reg      <= '0;
            bus_add_reg   <= '0;
            data_out_reg  <= '0;
            rsp_data_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            wr_reg        <= 1'b0;
            rd_reg        <= 1'b0;
        end else begin
            wr_reg <= 1'b0;
            rd_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_accept) begin
                        dir_reg    <= bus.CMD_DATA[7];
                        remain_reg <= bus.CMD_DATA[6:0];
                        state_reg  <= ADDR_H;
                    end
                end
                ADDR_H: begin
                    if (cmd_accept) begin
                        addr_h_reg <= bus.CMD_DATA;
                        state_reg  <= ADDR_L;
                    end
                end
                ADDR_L: begin
                    if (cmd_accept) begin
                        addr_reg <= addr_frame;
                        if (dir_reg) begin
                            bus_add_reg <= addr_frame;
                            rd_reg      <= 1'b1;
                            state_reg   <= RD_STROBE;
                        end else begin
                            state_reg <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (cmd_accept) begin
                        data_out_reg <= bus.CMD_DATA;
                        bus_add_reg  <= addr_reg;
                        wr_reg       <= 1'b1;
                        state_reg    <= WR_STROBE;
                    end
                end
                WR_STROBE: begin
                    addr_reg <= addr_next;
                    if (last_xfer) begin
                        state_reg <= IDLE;
                    end else begin
                        remain_reg <= remain_reg - 7'd1;
                        state_reg  <= WR_DATA;
                    end
                end
                RD_STROBE: begin
                    wait_reg  <= '0;
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_reg == 2'(READ_LATENCY - 1)) begin
                        rsp_data_reg  <= bus.BUS_DATA_IN;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RD_OUT;
                    end else begin
                        wait_reg <= wait_reg + 2'd1;
                    end
                end
                RD_OUT: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_reg <= 1'b0;
                        addr_reg      <= addr_next;
                        if (last_xfer) begin
                            state_reg <= IDLE;
                        end else begin
                            remain_reg  <= remain_reg - 7'd1;
                            bus_add_reg <= addr_next;
                            rd_reg      <= 1'b1;
                            state_reg   <= RD_STROBE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.CMD_READY    = cmd_ready;
    assign bus.BUSY         = (state_reg != IDLE);
    assign bus.BUS_ADD      = bus_add_reg;
    assign bus.BUS_DATA_OUT = data_out_reg;
    assign bus.BUS_WR       = wr_reg;
    assign bus.BUS_RD       = rd_reg;
    assign bus.RSP_DATA     = rsp_data_reg;
    assign bus.RSP_VALID    = rsp_valid_reg;
endmodule

// File: tb/tb_cmd_to_sbus.sv
// Randomized self-checking bench for cmd_to_sbus: a frame-level reference
// model predicts bus transactions and returned read bytes.
module tb_cmd_to_sbus;
    localparam int RL = 1;
    localparam int AW = 16;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic BUS_CLK   = 1'b0;
    logic BUS_RST_N = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    cmd_to_sbus_if #(.ABUSWIDTH(AW)) sb ();
    cmd_to_sbus #(.READ_LATENCY(RL), .ABUSWIDTH(AW)) dut (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST_N(BUS_RST_N),
        .bus      (sb)
    );

    txn_t        bus_q[$];
    txn_t        exp_bus_q[$];
    int          bus_cyc_q[$];
    logic [7:0]  rsp_q[$];
    logic [7:0]  exp_rsp_q[$];
    logic [7:0]  mem [0:65535];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          both_cnt = 0;
    int          wide_cnt = 0;
    bit          prev_wr = 1'b0;
    bit          prev_rd = 1'b0;

    // Bus slave: valid data only in the cycle READ_LATENCY after the strobe,
    // inverted data otherwise so a mistimed sample is always wrong.
    bit          rd_pipe [RL];
    logic [15:0] ad_pipe [RL];
    assign sb.BUS_DATA_IN = rd_pipe[RL-1] ? mem[ad_pipe[RL-1]] : ~mem[sb.BUS_ADD];

    always @(posedge BUS_CLK) begin
        cyc        <= cyc + 1;
        rd_pipe[0] <= sb.BUS_RD;
        ad_pipe[0] <= sb.BUS_ADD;
        for (int k = 1; k < RL; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
            ad_pipe[k] <= ad_pipe[k-1];
        end
        prev_wr <= sb.BUS_WR;
        prev_rd <= sb.BUS_RD;
        if (sb.BUS_WR && sb.BUS_RD) both_cnt <= both_cnt + 1;
        if ((sb.BUS_WR && prev_wr) || (sb.BUS_RD && prev_rd)) wide_cnt <= wide_cnt + 1;
        if (sb.BUS_WR || sb.BUS_RD) begin
            bus_q.push_back(txn_t'{wr: sb.BUS_WR, addr: sb.BUS_ADD,
                                   data: sb.BUS_WR ? sb.BUS_DATA_OUT : 8'h00});
            bus_cyc_q.push_back(cyc);
            $display("bus %s addr=%04h data=%02h", sb.BUS_WR ? "WR" : "RD", sb.BUS_ADD,
                     sb.BUS_WR ? sb.BUS_DATA_OUT : sb.BUS_DATA_IN);
        end
        if (sb.RSP_VALID && sb.RSP_READY) begin
            rsp_q.push_back(sb.RSP_DATA);
            $display("rsp data=%02h", sb.RSP_DATA);
        end
    end

    // Reference model: N = cmd[6:0]+1 transactions at addr, addr+1, ... mod 2^16.
    function automatic void model_frame(input logic [7:0] cmd, input logic [15:0] addr,
                                        input byte_q_t data);
        int n = int'(cmd[6:0]) + 1;
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            a = addr + 16'(i);
            if (cmd[7]) begin
                exp_bus_q.push_back(txn_t'{wr: 1'b0, addr: a, data: 8'h00});
                exp_rsp_q.push_back(mem[a]);
            end else begin
                exp_bus_q.push_back(txn_t'{wr: 1'b1, addr: a, data: data[i]});
            end
        end
    endfunction

    function automatic int bus_diffs();
        int d = (bus_q.size() != exp_bus_q.size()) ? 1 : 0;
        for (int i = 0; i < bus_q.size() && i < exp_bus_q.size(); i++)
            if (bus_q[i] !== exp_bus_q[i]) d++;
        return d;
    endfunction

    function automatic int rsp_diffs();
        int d = (rsp_q.size() != exp_rsp_q.size()) ? 1 : 0;
        for (int i = 0; i < rsp_q.size() && i < exp_rsp_q.size(); i++)
            if (rsp_q[i] !== exp_rsp_q[i]) d++;
        return d;
    endfunction

    function automatic void clear_all();
        bus_q.delete();
        bus_cyc_q.delete();
        rsp_q.delete();
        exp_bus_q.delete();
        exp_rsp_q.delete();
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        int n = 0;
        if (gap > 0) begin
            sb.CMD_VALID = 1'b0;
            repeat (gap) @(negedge BUS_CLK);
        end
        sb.CMD_VALID = 1'b1;
        sb.CMD_DATA  = b;
        while (!sb.CMD_READY && n < 2000) begin
            @(negedge BUS_CLK);
            n++;
        end
        if (!sb.CMD_READY) begin
            total_cnt++;
            $display("FAIL cmd_accept_timeout: byte %02h, CMD_READY=%0b required 1", b, sb.CMD_READY);
        end
        @(negedge BUS_CLK);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                              input byte_q_t data, input int max_gap);
        send_byte(cmd, max_gap);
        send_byte(addr[15:8], max_gap);
        send_byte(addr[7:0], max_gap);
        if (!cmd[7])
            for (int i = 0; i <= int'(cmd[6:0]); i++) send_byte(data[i], max_gap);
        sb.CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_ready);
        int n = 0;
        while (sb.BUSY && n < 5000) begin
            if (rand_ready) sb.RSP_READY = 1'($urandom_range(1, 0));
            @(negedge BUS_CLK);
            n++;
        end
        if (sb.BUSY) begin
            total_cnt++;
            $display("FAIL idle_timeout: BUSY=%0b required 0", sb.BUSY);
        end
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!sb.RSP_VALID && n < 100) begin
            @(negedge BUS_CLK);
            n++;
        end
        if (!sb.RSP_VALID) begin
            total_cnt++;
            $display("FAIL rsp_valid_timeout: RSP_VALID=%0b required 1", sb.RSP_VALID);
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        sb.CMD_VALID = 1'b1;
        repeat (3) @(negedge BUS_CLK);
        outs = {sb.BUS_ADD, sb.BUS_DATA_OUT, sb.BUS_WR, sb.BUS_RD, sb.RSP_VALID, sb.BUSY, 4'h0};
        total_cnt++;
        if (outs !== 32'h0) $display("FAIL reset_outputs: got %08h required 00000000", outs);
        else pass_cnt++;
        total_cnt++;
        if (sb.RSP_DATA !== 8'h00) $display("FAIL reset_rsp_data: got %02h required 00", sb.RSP_DATA);
        else pass_cnt++;
        total_cnt++;
        if (sb.CMD_READY !== 1'b0) $display("FAIL reset_cmd_ready: got %0b required 0", sb.CMD_READY);
        else pass_cnt++;
        sb.CMD_VALID = 1'b0;
        BUS_RST_N = 1'b1;
        @(negedge BUS_CLK);
        total_cnt++;
        if (sb.CMD_READY !== 1'b1) $display("FAIL idle_cmd_ready: got %0b required 1", sb.CMD_READY);
        else pass_cnt++;
    endtask

    task automatic test_write_burst(input int max_gap);
        logic [15:0] ea [3] = '{16'h0001, 16'h0002, 16'h0003};
        logic [7:0]  ed [3] = '{8'hAA, 8'h55, 8'h0F};
        byte_q_t d = '{8'hAA, 8'h55, 8'h0F};
        int w0 = wide_cnt;
        txn_t t;
        clear_all();
        model_frame(8'h02, 16'h0001, d);
        send_frame(8'h02, 16'h0001, d, max_gap);
        wait_idle(1'b0);
        total_cnt++;
        if (bus_diffs() !== 0) $display("FAIL wr_burst_model gap=%0d: %0d diffs required 0", max_gap, bus_diffs());
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            t = (i < bus_q.size()) ? bus_q[i] : txn_t'('0);
            total_cnt++;
            if (t !== txn_t'{wr: 1'b1, addr: ea[i], data: ed[i]})
                $display("FAIL wr_burst_txn%0d: got wr=%0b %04h/%02h required wr=1 %04h/%02h",
                         i, t.wr, t.addr, t.data, ea[i], ed[i]);
            else pass_cnt++;
        end
        if (max_gap == 0) begin
            total_cnt++;
            if (bus_cyc_q.size() !== 3 || bus_cyc_q[1] - bus_cyc_q[0] !== 2 || bus_cyc_q[2] - bus_cyc_q[1] !== 2)
                $display("FAIL wr_spacing: %0d strobes, not all 2 cycles apart; required 3 at 2-cycle spacing",
                         bus_cyc_q.size());
            else pass_cnt++;
        end
        total_cnt++;
        if (wide_cnt - w0 !== 0) $display("FAIL wr_pulse_width: %0d wide pulses required 0", wide_cnt - w0);
        else pass_cnt++;
        total_cnt++;
        if (sb.BUSY !== 1'b0) $display("FAIL wr_busy_after: got %0b required 0", sb.BUSY);
        else pass_cnt++;
    endtask

    task automatic test_read_burst();
        byte_q_t none;
        int wr_seen = 0;
        int b0 = both_cnt;
        clear_all();
        sb.RSP_READY = 1'b1;
        model_frame(8'h81, 16'h0010, none);
        send_frame(8'h81, 16'h0010, none, 0);
        wait_idle(1'b0);
        total_cnt++;
        if (bus_diffs() !== 0) $display("FAIL rd_burst_bus: %0d diffs required 0", bus_diffs());
        else pass_cnt++;
        total_cnt++;
        if (rsp_q.size() !== 2 || rsp_q[0] !== 8'hCD || rsp_q[1] !== 8'hA5)
            $display("FAIL rd_burst_rsp: got %0d bytes first %02h required 2 bytes CD,A5",
                     rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 8'h00);
        else pass_cnt++;
        foreach (bus_q[i]) if (bus_q[i].wr) wr_seen++;
        total_cnt++;
        if (wr_seen !== 0 || both_cnt - b0 !== 0)
            $display("FAIL rd_no_write: got %0d writes required 0", wr_seen);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        byte_q_t none;
        int bad = 0;
        clear_all();
        sb.RSP_READY = 1'b0;
        model_frame(8'h81, 16'h0010, none);
        send_frame(8'h81, 16'h0010, none, 0);
        wait_rsp_valid();
        for (int k = 0; k < 10; k++) begin
            if (sb.RSP_VALID !== 1'b1 || sb.RSP_DATA !== 8'hCD) bad++;
            @(negedge BUS_CLK);
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (bus_q.size() !== 1) $display("FAIL bp_single_strobe: got %0d strobes required 1", bus_q.size());
        else pass_cnt++;
        sb.RSP_READY = 1'b1;
        wait_idle(1'b0);
        total_cnt++;
        if (rsp_diffs() !== 0 || bus_diffs() !== 0)
            $display("FAIL bp_complete: %0d rsp diffs, %0d bus diffs required 0", rsp_diffs(), bus_diffs());
        else pass_cnt++;
    endtask

    task automatic test_wrap_length();
        byte_q_t d = '{8'h11, 8'h22};
        logic [15:0] a;
        clear_all();
        model_frame(8'h01, 16'hFFFF, d);
        send_frame(8'h01, 16'hFFFF, d, 0);
        wait_idle(1'b0);
        total_cnt++;
        if (bus_diffs() !== 0 || bus_q.size() !== 2 || bus_q[1].addr !== 16'h0000)
            $display("FAIL wrap: %0d diffs, %0d strobes required 0 diffs, writes at FFFF then 0000",
                     bus_diffs(), bus_q.size());
        else pass_cnt++;
        clear_all();
        a = 16'($urandom);
        d = rand_bytes(1);
        model_frame(8'h00, a, d);
        send_frame(8'h00, a, d, 0);
        wait_idle(1'b0);
        total_cnt++;
        if (bus_q.size() !== 1 || bus_diffs() !== 0)
            $display("FAIL len_1: got %0d strobes required 1", bus_q.size());
        else pass_cnt++;
        clear_all();
        a = 16'($urandom);
        d = rand_bytes(128);
        model_frame(8'h7F, a, d);
        send_frame(8'h7F, a, d, 0);
        wait_idle(1'b0);
        total_cnt++;
        if (bus_q.size() !== 128 || bus_diffs() !== 0)
            $display("FAIL len_128: got %0d strobes, %0d diffs required 128 strobes, 0 diffs",
                     bus_q.size(), bus_diffs());
        else pass_cnt++;
    endtask

    task automatic test_random_frames();
        logic [7:0]  cmd;
        logic [15:0] a;
        byte_q_t     d;
        for (int f = 0; f < 10; f++) begin
            clear_all();
            cmd = {1'($urandom_range(1, 0)), 7'($urandom_range(15, 0))};
            a   = 16'($urandom);
            if (f == 0) a = 16'hFFFE;
            d   = rand_bytes(int'(cmd[6:0]) + 1);
            sb.RSP_READY = 1'b1;
            model_frame(cmd, a, d);
            send_frame(cmd, a, d, 5);
            wait_idle(1'b1);
            sb.RSP_READY = 1'b1;
            total_cnt++;
            if (bus_diffs() !== 0 || rsp_diffs() !== 0)
                $display("FAIL random_frame%0d cmd=%02h addr=%04h: %0d bus, %0d rsp diffs required 0",
                         f, cmd, a, bus_diffs(), rsp_diffs());
            else pass_cnt++;
        end
        total_cnt++;
        if (both_cnt !== 0 || wide_cnt !== 0)
            $display("FAIL strobe_rules: %0d overlaps, %0d wide pulses required 0", both_cnt, wide_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        byte_q_t none;
        byte_q_t d = '{8'h77};
        logic [3:0] outs;
        clear_all();
        sb.RSP_READY = 1'b0;
        send_frame(8'h83, 16'($urandom), none, 0);
        wait_rsp_valid();
        BUS_RST_N = 1'b0;
        #1;
        outs = {sb.BUS_RD, sb.BUS_WR, sb.RSP_VALID, sb.BUSY};
        total_cnt++;
        if (outs !== 4'b0000) $display("FAIL mid_reset_outputs: RD,WR,RSP_VALID,BUSY=%04b required 0000", outs);
        else pass_cnt++;
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        sb.RSP_READY = 1'b1;
        @(negedge BUS_CLK);
        clear_all();
        model_frame(8'h00, 16'h0005, d);
        send_frame(8'h00, 16'h0005, d, 0);
        wait_idle(1'b0);
        total_cnt++;
        if (bus_q.size() !== 1 || bus_diffs() !== 0 || rsp_q.size() !== 0)
            $display("FAIL after_reset_write: %0d strobes, %0d diffs required one write 77 at 0005",
                     bus_q.size(), bus_diffs());
        else pass_cnt++;
    endtask

    initial begin
        sb.CMD_VALID = 1'b0;
        sb.CMD_DATA  = 8'h00;
        sb.RSP_READY = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'hCD;
        mem[16'h0011] = 8'hA5;
        test_reset();
        test_write_burst(0);
        test_read_burst();
        test_backpressure();
        test_wrap_length();
        test_write_burst(5);
        test_random_frames();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
